// File: rtl/attosoc_mem_arbiter_pkg.sv
// Shared definitions for the attosoc two-master memory arbiter:
// bus widths, FSM state encoding, request bundle and the winner-selection helper.
package attosoc_mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_req_t;

    // Winner index. When both masters request, the one not served last wins.
    function automatic logic pick_winner(
        input logic v0,
        input logic v1,
        input logic last
    );
        if (v0 && v1) begin
            return ~last;
        end
        return v1;
    endfunction

endpackage

// File: rtl/attosoc_mem_arbiter_watchdog.sv
// Saturating grant watchdog: counts enabled cycles since the last clear.
// Ports: clk, resetn, clear (zero the count), enable (count one cycle), expire (count reached limit).
module attosoc_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // A zero limit still needs one counter bit; that bit never moves.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/attosoc_mem_arbiter.sv
// Two-master round-robin arbiter for the native memory bus, with a grant watchdog
// that terminates stalled transfers with an error response.
// Ports: clk/resetn; m0_* and m1_* master requests and responses; s_* forwarded request
// to the decoder and its ready/rdata; owner = current/last grant; timeout_err = watchdog pulse.
module attosoc_mem_arbiter
    import attosoc_mem_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic              m0_instr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_instr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_valid,
    output logic              s_instr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              owner,
    output logic              timeout_err
);

    state_t   state;
    state_t   state_nxt;
    logic     owner_nxt;
    logic     last;
    logic     last_nxt;
    bus_req_t req0;
    bus_req_t req1;
    bus_req_t sel;
    logic     own_valid;
    logic     expire;
    logic     done;
    logic     tout;
    logic     respond;
    logic [DATA_W-1:0] resp_data;

    assign req0      = {m0_instr, m0_addr, m0_wdata, m0_wstrb};
    assign req1      = {m1_instr, m1_addr, m1_wdata, m1_wstrb};
    assign sel       = owner ? req1 : req0;
    assign own_valid = owner ? m1_valid : m0_valid;

    // A late s_ready beats an expiring watchdog in the same cycle.
    assign done = (state == ST_GRANT) && own_valid && s_ready;
    assign tout = (state == ST_GRANT) && own_valid && expire && !s_ready;

    attosoc_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .resetn(resetn),
        .clear (state == ST_IDLE),
        .enable((state == ST_GRANT) && !s_ready),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last;
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        respond     = 1'b0;
        resp_data   = '0;
        timeout_err = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    owner_nxt = pick_winner(m0_valid, m1_valid, last);
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                s_valid = own_valid && !tout;
                s_instr = sel.instr;
                s_addr  = sel.addr;
                s_wdata = sel.wdata;
                s_wstrb = sel.wstrb;
                if (done) begin
                    respond   = 1'b1;
                    resp_data = s_rdata;
                    last_nxt  = owner;
                    state_nxt = ST_IDLE;
                end else if (tout) begin
                    respond     = 1'b1;
                    resp_data   = ERR_RDATA;
                    timeout_err = 1'b1;
                    state_nxt   = ST_IDLE;
                end else if (!own_valid) begin
                    // Master abandoned the request: release without a ready.
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    assign m0_ready = respond && !owner;
    assign m1_ready = respond && owner;
    assign m0_rdata = (respond && !owner) ? resp_data : '0;
    assign m1_rdata = (respond && owner) ? resp_data : '0;

endmodule
